// File: rtl/clock_set_controller.sv
// Button sequencer for the digital clock: synchronizes mode/up/down, walks the
// digit-selection FSM and issues set/select/up/down/blink with hold-to-repeat and idle timeout.
module clock_set_controller #(
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100,
   parameter int unsigned IDLE_TIMEOUT = 10000,
   parameter int unsigned BLINK_HALF   = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       set,
   output logic [2:0] select,
   output logic       up,
   output logic       down,
   output logic       blink,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      RUN  = 3'd0,
      S_H2 = 3'd1,
      S_H1 = 3'd2,
      S_M2 = 3'd3,
      S_M1 = 3'd4,
      S_S2 = 3'd5,
      S_S1 = 3'd6
   } state_t;

   state_t      state;
   logic [2:0]  sync1, sync2, prev;   // bit 0 mode, bit 1 up, bit 2 down
   logic [31:0] rpt_cnt, idle_cnt, blink_cnt;
   logic        rpt_up, rpt_dn, rpt_first, block;

   logic        mode_e, up_e, dn_e, up_l, dn_l, both, in_set;
   logic        rpt_due, fire_up, fire_dn, activity, timeout;
   logic [31:0] rpt_target, idle_next;
   state_t      nxt_state;

   function automatic state_t advance(input state_t s);
      case (s)
         RUN:     advance = S_H2;
         S_H2:    advance = S_H1;
         S_H1:    advance = S_M2;
         S_M2:    advance = S_M1;
         S_M1:    advance = S_S2;
         S_S2:    advance = S_S1;
         default: advance = RUN;
      endcase
   endfunction

   function automatic logic [2:0] sel_of(input state_t s);
      case (s)
         S_H2:    sel_of = 3'b101;
         S_H1:    sel_of = 3'b100;
         S_M2:    sel_of = 3'b011;
         S_M1:    sel_of = 3'b010;
         S_S2:    sel_of = 3'b001;
         default: sel_of = 3'b000;
      endcase
   endfunction

   always_comb begin
      mode_e     = sync2[0] & ~prev[0];
      up_e       = sync2[1] & ~prev[1];
      dn_e       = sync2[2] & ~prev[2];
      up_l       = sync2[1];
      dn_l       = sync2[2];
      both       = up_l & dn_l;
      in_set     = (state != RUN);
      rpt_target = rpt_first ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE);
      rpt_due    = (rpt_cnt == rpt_target);
      // Mode edge wins over any up/down pulse in the same cycle.
      fire_up    = in_set && !mode_e && !both && !block && (up_e || (rpt_up && up_l && rpt_due));
      fire_dn    = in_set && !mode_e && !both && !block && (dn_e || (rpt_dn && dn_l && rpt_due));
      activity   = mode_e | up_e | dn_e | fire_up | fire_dn;
      idle_next  = (idle_cnt == 32'(IDLE_TIMEOUT)) ? idle_cnt : idle_cnt + 32'd1;
      timeout    = (IDLE_TIMEOUT != 0) && !activity && (idle_next == 32'(IDLE_TIMEOUT));
      nxt_state  = advance(state);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         sync1     <= 3'b000;
         sync2     <= 3'b000;
         prev      <= 3'b000;
         rpt_cnt   <= 32'd0;
         idle_cnt  <= 32'd0;
         blink_cnt <= 32'd0;
         rpt_up    <= 1'b0;
         rpt_dn    <= 1'b0;
         rpt_first <= 1'b0;
         block     <= 1'b0;
         set       <= 1'b0;
         select    <= 3'b000;
         up        <= 1'b0;
         down      <= 1'b0;
         blink     <= 1'b0;
      end else begin
         sync1 <= {btn_down, btn_up, btn_mode};
         sync2 <= sync1;
         prev  <= sync2;
         up    <= 1'b0;
         down  <= 1'b0;
         if (state == RUN) begin
            idle_cnt  <= 32'd0;
            rpt_cnt   <= 32'd0;
            rpt_up    <= 1'b0;
            rpt_dn    <= 1'b0;
            block     <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= 32'd0;
            if (mode_e) begin
               state  <= nxt_state;
               set    <= 1'b1;
               select <= sel_of(nxt_state);
               blink  <= 1'b1;
            end
         end else begin
            // Once both buttons are seen together, stay muted until both are released.
            if (both)
               block <= 1'b1;
            else if (!up_l && !dn_l)
               block <= 1'b0;

            idle_cnt <= activity ? 32'd0 : idle_next;

            if (blink_cnt + 32'd1 == 32'(BLINK_HALF)) begin
               blink     <= ~blink;
               blink_cnt <= 32'd0;
            end else begin
               blink_cnt <= blink_cnt + 32'd1;
            end

            if ((rpt_up || rpt_dn) && !rpt_due)
               rpt_cnt <= rpt_cnt + 32'd1;

            if (mode_e) begin
               state     <= nxt_state;
               set       <= (nxt_state != RUN);
               select    <= sel_of(nxt_state);
               blink     <= (nxt_state != RUN);
               blink_cnt <= 32'd0;
               rpt_up    <= 1'b0;
               rpt_dn    <= 1'b0;
               rpt_cnt   <= 32'd0;
            end else if (timeout) begin
               state   <= RUN;
               set     <= 1'b0;
               select  <= 3'b000;
               blink   <= 1'b0;
               rpt_up  <= 1'b0;
               rpt_dn  <= 1'b0;
               rpt_cnt <= 32'd0;
            end else if (fire_up || fire_dn) begin
               up        <= fire_up;
               down      <= fire_dn;
               rpt_up    <= fire_up;
               rpt_dn    <= fire_dn;
               rpt_first <= up_e | dn_e;
               rpt_cnt   <= 32'd1;
               blink     <= 1'b1;
               blink_cnt <= 32'd0;
            end else if (both || (rpt_up && !up_l) || (rpt_dn && !dn_l)) begin
               rpt_up  <= 1'b0;
               rpt_dn  <= 1'b0;
               rpt_cnt <= 32'd0;
            end
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic,
// all checked each cycle against a timestamp-based reference model.
module tb_clock_set_controller;

   localparam int RD = 8;
   localparam int RR = 3;
   localparam int IT = 50;
   localparam int BH = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic       set, up, down, blink;
   logic [2:0] select, state_dbg;

   clock_set_controller #(
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .IDLE_TIMEOUT(IT), .BLINK_HALF(BH)
   ) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .set(set), .select(select), .up(up), .down(down), .blink(blink), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int ups = 0;
   int dns = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: state index, absolute-cycle timestamps for repeat due time,
   // last activity and blink phase origin; button history as 4-entry delay lines.
   int       mc = 0;
   int       m_state = 0, m_dir = 0, m_due = 0, m_last = 0, m_bref = 0;
   bit       m_block = 0, m_up = 0, m_down = 0;
   bit [3:0] hm = '0, hu = '0, hd = '0;

   function automatic logic [2:0] sel_exp(input int s);
      case (s)
         1: sel_exp = 3'd5;
         2: sel_exp = 3'd4;
         3: sel_exp = 3'd3;
         4: sel_exp = 3'd2;
         5: sel_exp = 3'd1;
         default: sel_exp = 3'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model_blk
      bit lu, ld, em, eu, ed, both, fu, fd;
      mc++;
      m_up = 0;
      m_down = 0;
      if (rst) begin
         hm = '0; hu = '0; hd = '0;
         m_state = 0; m_dir = 0; m_block = 0;
      end else begin
         hm[mc % 4] = btn_mode;
         hu[mc % 4] = btn_up;
         hd[mc % 4] = btn_down;
         em = hm[(mc + 2) % 4] & ~hm[(mc + 1) % 4];
         eu = hu[(mc + 2) % 4] & ~hu[(mc + 1) % 4];
         ed = hd[(mc + 2) % 4] & ~hd[(mc + 1) % 4];
         lu = hu[(mc + 2) % 4];
         ld = hd[(mc + 2) % 4];
         if (m_state == 0) begin
            m_dir = 0;
            m_block = 0;
            if (em) begin
               m_state = 1; m_bref = mc; m_last = mc;
            end
         end else begin
            both = lu & ld;
            fu = !em && !both && !m_block && (eu || (m_dir == 1 && lu && mc == m_due));
            fd = !em && !both && !m_block && (ed || (m_dir == 2 && ld && mc == m_due));
            if (both) m_block = 1;
            else if (!lu && !ld) m_block = 0;
            if (em | eu | ed | fu | fd) m_last = mc;
            if (em) begin
               m_state = (m_state == 6) ? 0 : m_state + 1;
               m_bref = mc;
               m_dir = 0;
            end else if (mc - m_last == IT) begin
               m_state = 0;
               m_dir = 0;
            end else if (fu | fd) begin
               m_up = fu;
               m_down = fd;
               m_dir = fu ? 1 : 2;
               m_due = mc + ((eu | ed) ? RD : RR);
               m_bref = mc;
            end else if (both || (m_dir == 1 && !lu) || (m_dir == 2 && !ld)) begin
               m_dir = 0;
            end
         end
      end
   end

   task automatic tick(input logic r, input logic m, input logic u, input logic d);
      rst = r; btn_mode = m; btn_up = u; btn_down = d;
      @(negedge clk);
      chk("state", state_dbg, m_state);
      chk("set", set, m_state != 0);
      chk("select", select, sel_exp(m_state));
      chk("up", up, m_up);
      chk("down", down, m_down);
      chk("blink", blink, (m_state != 0) && ((((mc - m_bref) / BH) % 2) == 0));
      if (up) ups++;
      if (down) dns++;
   endtask

   task automatic press_mode();
      tick(0, 1, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [2:0] t1_sel [7];
      int lat, u0, d0, t_enter, t_drop;
      int tq[$];
      int gaps[4];
      bit cm, cu, cd;
      int quiet;

      t1_sel = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      gaps = '{RD, RR, RR, RR};

      // 1. Reset and the mode walk
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("rst_state", state_dbg, 0);
      chk("rst_set", set, 0);
      chk("rst_select", select, 0);
      chk("rst_updown", {up, down}, 0);
      chk("rst_blink", blink, 0);
      tick(0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         press_mode();
         chk("t1_select", select, t1_sel[i]);
         chk("t1_set", set, i < 6);
      end

      // 2. Pulse latency in S_M1
      repeat (4) press_mode();
      chk("t2_state", state_dbg, 4);
      lat = 0; u0 = ups; d0 = dns;
      for (int k = 1; k <= 12; k++) begin
         tick(0, 0, k <= 3, 0);
         if (up && lat == 0) lat = k;
      end
      chk("t2_latency", lat, 3);
      chk("t2_ups", ups - u0, 1);
      chk("t2_downs", dns - d0, 0);

      // 3. Auto-repeat in S_S2
      press_mode();
      chk("t3_state", state_dbg, 5);
      for (int k = 1; k <= 26; k++) begin
         tick(0, 0, 0, k <= 20);
         if (down) tq.push_back(k);
      end
      chk("t3_count", tq.size(), 5);
      chk("t3_first", (tq.size() > 0) ? tq[0] : -1, 3);
      for (int i = 1; i < 5; i++)
         chk("t3_gap", (tq.size() > i) ? tq[i] - tq[i-1] : -1, gaps[i-1]);

      // 4. Both buttons in S_H1
      repeat (4) press_mode();
      chk("t4_state", state_dbg, 2);
      u0 = ups; d0 = dns;
      repeat (6) tick(0, 0, 1, 1);
      repeat (6) tick(0, 0, 1, 0);
      chk("t4_none", (ups - u0) + (dns - d0), 0);
      repeat (2) tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      repeat (4) tick(0, 0, 0, 0);
      chk("t4_repress", ups - u0, 1);
      chk("t4_repress_dn", dns - d0, 0);

      // 5. Mode priority and idle timeout
      tick(1, 0, 0, 0);
      press_mode();
      chk("t5_state0", state_dbg, 1);
      u0 = ups; t_enter = -1; t_drop = -1;
      for (int k = 1; k <= 120; k++) begin
         tick(0, k == 1, k == 1, 0);
         if (t_enter < 0 && state_dbg == 3'd2) t_enter = k;
         if (t_enter >= 0 && t_drop < 0 && set == 1'b0) t_drop = k;
      end
      chk("t5_enter", t_enter, 3);
      chk("t5_noup", ups - u0, 0);
      chk("t5_timeout", t_drop - t_enter, IT);

      // 6. Reset while a repeat is running in S_M2
      repeat (3) press_mode();
      chk("t6_state", state_dbg, 3);
      u0 = ups;
      repeat (14) tick(0, 0, 1, 0);
      chk("t6_repeat", ups - u0, 3);
      tick(1, 0, 1, 0);
      chk("t6_rst_state", state_dbg, 0);
      chk("t6_rst_out", {set, select, up, down, blink}, 0);
      u0 = ups;
      repeat (15) tick(0, 0, 1, 0);
      chk("t6_noup", ups - u0, 0);
      tick(0, 0, 0, 0);

      // Random traffic
      cm = 0; cu = 0; cd = 0; quiet = 0;
      for (int k = 0; k < 4000; k++) begin
         if (quiet > 0) begin
            quiet--;
            cm = 0; cu = 0; cd = 0;
         end else begin
            if ($urandom_range(0, 5) == 0) cm = ~cm;
            if ($urandom_range(0, 9) == 0) cu = ~cu;
            if ($urandom_range(0, 9) == 0) cd = ~cd;
            if ($urandom_range(0, 149) == 0) quiet = $urandom_range(40, 70);
         end
         tick($urandom_range(0, 999) == 0, cm, cu, cd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
User-interface sequencer for the digital clock datapath. Takes three raw push-buttons (mode, up, down) and synchronizes and edge-detects them. Walks a digit-selection FSM and emits the datapath's set, select, up and down controls, with hold-to-repeat and an inactivity timeout. Also drives a blink enable for the display digit being edited.

Parameters:
REPEAT_DELAY, 500, clk cycles from the initial up/down pulse to the first auto-repeat pulse while the button is held (>=1)
REPEAT_RATE, 100, clk cycles between subsequent auto-repeat pulses (>=1)
IDLE_TIMEOUT, 10000, clk cycles with no button edge in a SET state before returning to RUN; 0 disables the timeout
BLINK_HALF, 250, clk cycles per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_up  input  1  raw increment button, asynchronous, active-high
btn_down  input  1  raw decrement button, asynchronous, active-high
set  output  1  1 = datapath in set mode (clock halted)
select  output  3  digit select: 000 sec1, 001 sec2, 010 min1, 011 min2, 100 hour1, 101 hour2
up  output  1  one-cycle increment pulse for the selected digit
down  output  1  one-cycle decrement pulse for the selected digit
blink  output  1  display blink enable for the selected digit
state_dbg  output  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous, active-high.
- Reset state: FSM = RUN; set=0, select=000, up=0, down=0, blink=0, state_dbg=0. All counters and synchronizer flops are cleared.
- rst asserted mid-operation: the next edge forces the full reset state. Any in-progress repeat or timeout is discarded.
- Input synchronizers: each button passes through a 2-flop synchronizer, followed by a registered previous-value flop for rising-edge detection.
- Latency: a button sampled high at edge E gives a synchronized level at E+1, and the registered output pulse appears after edge E+2, lasting exactly one cycle.
- FSM states and encoding: RUN=0, S_H2=1, S_H1=2, S_M2=3, S_M1=4, S_S2=5, S_S1=6.
- Mode rising edge advances the FSM: RUN -> S_H2 -> S_H1 -> S_M2 -> S_M1 -> S_S2 -> S_S1 -> RUN.
- select per state: S_H2=101, S_H1=100, S_M2=011, S_M1=010, S_S2=001, S_S1=000, RUN=000.
- set is 1 in every S_* state and 0 in RUN. set and select are registered and change together.
- RUN: up, down and blink are held at 0. Up/down buttons are ignored and do not arm the repeat counter.
- Single press in an S_* state: a rising edge of up (or down) produces one up (or down) pulse and arms the repeat counter.
- Auto-repeat: while the synchronized level stays high, the next pulse fires REPEAT_DELAY cycles after the initial pulse. Further pulses follow every REPEAT_RATE cycles.
- Releasing the button clears the repeat counter.
- Both up and down synchronized levels high: no pulses. The repeat counter is cleared and held until both are released. A press of either one alone then restarts normal operation.
- Mode edge in the same cycle as an up/down pulse (edge or repeat): mode wins. The FSM advances, the up/down pulse is suppressed, and the repeat counter is cleared.
- up and down are never high in the same cycle. Neither is ever high while set=0.
- Idle timeout: the idle counter resets on any rising edge of any button, including auto-repeat pulses.
- When the idle counter reaches IDLE_TIMEOUT in an S_* state, the FSM goes to RUN (set=0, select=000, blink=0). The idle counter is not running in RUN.
- Blink: on entry to any S_* state, blink=1 and the blink counter is cleared. blink then toggles every BLINK_HALF cycles.
- Each up/down pulse forces blink=1 and restarts the blink counter, so the edited digit is visible.
- Counters are 32-bit unsigned, saturating at their terminal compare value (no wrap).
- The controller holds no knowledge of digit limits: range clamping and wrap of the digit values stay in the datapath.

Test Plan:
1. Reset: with rst=1 for 2 cycles, every output reads 0 and state_dbg=0. Six mode presses step select 101,100,011,010,001,000 with set=1; the seventh press returns set=0, select=000.
2. Pulse latency (REPEAT_DELAY=8, REPEAT_RATE=3): in S_M1, raise btn_up at edge 10 and hold 3 cycles. up is high for exactly one cycle after edge 12; down stays 0; no repeat pulse follows.
3. Auto-repeat (REPEAT_DELAY=8, REPEAT_RATE=3): hold btn_down for 20 cycles in S_S2. down pulses occur at T, T+8, T+11, T+14, T+17 and stop within 2 cycles of release.
4. Both buttons: press btn_up and btn_down together in S_H1. No up/down pulses occur; releasing down leaves no pulse until up is re-pressed.
5. Mode priority and timeout (IDLE_TIMEOUT=50): mode and up edges aligned in S_H2 give state S_H1 and no up pulse. With no further activity, set drops to 0 and state_dbg=0 exactly 50 cycles after the last edge.
6. Reset mid-operation: while holding btn_up in S_M2 with repeat active, a 1-cycle rst gives all outputs 0 on the next cycle. The still-held up produces no pulse in RUN.
